// File: rtl/si_to_soe_gen_if.sv
// Handshake bundle for si_to_soe_gen: vector input side, beat output side and the enable qualifier.
// The master modport is the surrounding environment; the slave modport is the converter.
interface si_to_soe_gen_if #(
    parameter int IN_WIDTH = 10,
    parameter int N_IN     = 10,
    parameter int N_OUT    = 5
);
    localparam int BEATS = (N_IN + N_OUT - 1) / N_OUT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                      enable;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_IN*IN_WIDTH-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*IN_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]          out_beat;
    logic                      out_first;
    logic                      out_last;

    modport master (
        output enable, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_beat, out_first, out_last
    );

    modport slave (
        input  enable, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_beat, out_first, out_last
    );
endinterface

// File: rtl/si_to_soe_gen.sv
// Parallel-in to series-of-elements converter: one N_IN-element vector in, BEATS beats of N_OUT elements out.
// Define SI_TO_SOE_GEN_ZERO_PAD_EN to allow N_IN not a multiple of N_OUT (missing lanes of the last beat read 0).
module si_to_soe_gen #(
    parameter int IN_WIDTH = 10,
    parameter int N_IN     = 10,
    parameter int N_OUT    = 5
) (
    input logic           clk,
    input logic           reset,
    si_to_soe_gen_if.slave bus
);
    localparam int BEATS  = (N_IN + N_OUT - 1) / N_OUT;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = N_OUT * IN_WIDTH;
    localparam int VEC_W  = N_IN * IN_WIDTH;
    localparam int PAD_W  = BEATS * BEAT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   vreg_q, vreg_d;
    logic [PAD_W-1:0]   vpad;
    logic [BEAT_W-1:0]  beat_data;
    logic               busy;
    logic               on_last;
    logic               in_ready;
    logic               in_fire;
    logic               out_fire;

`ifdef SI_TO_SOE_GEN_ZERO_PAD_EN
    // Elements past N_IN land in zero-filled lanes of the final beat.
    assign vpad = PAD_W'(vreg_q);
`else
    if (N_IN % N_OUT != 0) begin : g_bad_ratio
        $error("si_to_soe_gen: N_IN must be a multiple of N_OUT unless SI_TO_SOE_GEN_ZERO_PAD_EN is defined");
    end
    assign vpad = vreg_q;
`endif

    assign busy     = (state_q == BUSY);
    assign on_last  = (cnt_q == LAST);
    assign in_ready = bus.enable & ~reset & (~busy | (bus.out_ready & on_last));
    assign in_fire  = bus.enable & bus.in_valid & in_ready;
    assign out_fire = bus.enable & busy & bus.out_ready;

    always_comb begin
        beat_data = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                beat_data = vpad[b*BEAT_W +: BEAT_W];
            end
        end
    end

    // A load on the last beat takes priority, giving back-to-back vectors with no idle cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vreg_d  = vreg_q;
        if (in_fire) begin
            vreg_d  = bus.in_data;
            cnt_d   = '0;
            state_d = BUSY;
        end else if (out_fire) begin
            if (on_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vreg_q  <= vreg_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = busy;
    assign bus.out_data  = beat_data;
    assign bus.out_beat  = cnt_q;
    assign bus.out_first = busy & (cnt_q == '0);
    assign bus.out_last  = busy & on_last;
endmodule

// File: tb/tb_si_to_soe_gen.sv
// Directed bench for si_to_soe_gen at 10x10-bit in, 5 lanes out; adds a 7-in/3-out padded instance
// when SI_TO_SOE_GEN_ZERO_PAD_EN is defined.
module tb_si_to_soe_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    si_to_soe_gen_if #(.IN_WIDTH(10), .N_IN(10), .N_OUT(5)) bus ();
    si_to_soe_gen #(.IN_WIDTH(10), .N_IN(10), .N_OUT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [49:0] beat5(input int e0, input int e1, input int e2, input int e3, input int e4);
        return {10'(e4), 10'(e3), 10'(e2), 10'(e1), 10'(e0)};
    endfunction

    // {out_valid, out_beat, out_first, out_last, in_ready, out_data}
    function automatic logic [54:0] obs();
        return {bus.out_valid, bus.out_beat, bus.out_first, bus.out_last, bus.in_ready, bus.out_data};
    endfunction

    logic [49:0] a0, a1;
    logic [49:0] b0 [3];
    logic [49:0] b1 [3];
    logic [54:0] exp_v;

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        exp_v = {5'b00000, 50'b0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL reset_state: got %h expected %h", obs(), exp_v); else n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        reset = 1'b0; bus.enable = 1'b1; bus.in_valid = 1'b1; bus.in_data = {a1, a0}; bus.out_ready = 1'b1;
        #1;
        exp_v = {5'b00001, 50'b0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL basic_idle: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        exp_v = {5'b10100, a0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL basic_beat0: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b11011, a1};
        n_total++;
        if (obs() !== exp_v) $display("FAIL basic_beat1: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b00001, a0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL basic_done: got %h expected %h", obs(), exp_v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {b1[0], b0[0]}; bus.out_ready = 1'b1;
        #1;
        exp_v = {5'b00001, a0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL b2b_idle: got %h expected %h", obs(), exp_v); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) bus.in_data = {b1[k+1], b0[k+1]};
            bus.in_valid = (k < 2);
            #1;
            exp_v = {5'b10100, b0[k]};
            n_total++;
            if (obs() !== exp_v) $display("FAIL b2b_v%0d_beat0: got %h expected %h", k, obs(), exp_v); else n_pass++;
            @(negedge clk);
            #1;
            exp_v = {5'b11011, b1[k]};
            n_total++;
            if (obs() !== exp_v) $display("FAIL b2b_v%0d_beat1: got %h expected %h", k, obs(), exp_v); else n_pass++;
        end
        @(negedge clk);
        #1;
        exp_v = {5'b00001, b0[2]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL b2b_done: got %h expected %h", obs(), exp_v); else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {a1, a0}; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        exp_v = {5'b10100, a0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL bp_beat0: got %h expected %h", obs(), exp_v); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
            #1;
            n_total++;
            if (obs() !== exp_v) $display("FAIL bp_hold%0d: got %h expected %h", k, obs(), exp_v); else n_pass++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_total++;
        if (obs() !== exp_v) $display("FAIL bp_release: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b11011, a1};
        n_total++;
        if (obs() !== exp_v) $display("FAIL bp_beat1: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b00001, a0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL bp_done: got %h expected %h", obs(), exp_v); else n_pass++;
    endtask

    task automatic test_enable();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {b1[0], b0[0]}; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.enable = 1'b0;
        exp_v = {5'b10100, b0[0]};
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (obs() !== exp_v) $display("FAIL en_freeze%0d: got %h expected %h", k, obs(), exp_v); else n_pass++;
            @(negedge clk);
        end
        bus.enable = 1'b1;
        #1;
        n_total++;
        if (obs() !== exp_v) $display("FAIL en_resume_beat0: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b11011, b1[0]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL en_resume_beat1: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b00001, b0[0]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL en_done: got %h expected %h", obs(), exp_v); else n_pass++;
        bus.enable = 1'b0;
        #1;
        exp_v = {5'b00000, b0[0]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL en_idle_ready: got %h expected %h", obs(), exp_v); else n_pass++;
        bus.enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {b1[1], b0[1]}; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        exp_v = {5'b10100, b0[1]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL rstmid_beat0: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_v = {5'b11010, b1[1]};
        n_total++;
        if (obs() !== exp_v) $display("FAIL rstmid_beat1: got %h expected %h", obs(), exp_v); else n_pass++;
        @(negedge clk);
        #1;
        exp_v = {5'b00000, 50'b0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL rstmid_cleared: got %h expected %h", obs(), exp_v); else n_pass++;
        reset = 1'b0;
        #1;
        exp_v = {5'b00001, 50'b0};
        n_total++;
        if (obs() !== exp_v) $display("FAIL rstmid_ready: got %h expected %h", obs(), exp_v); else n_pass++;
    endtask

`ifdef SI_TO_SOE_GEN_ZERO_PAD_EN
    si_to_soe_gen_if #(.IN_WIDTH(10), .N_IN(7), .N_OUT(3)) bus2 ();
    si_to_soe_gen #(.IN_WIDTH(10), .N_IN(7), .N_OUT(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    function automatic logic [35:0] obs2();
        return {bus2.out_valid, bus2.out_beat, bus2.out_first, bus2.out_last, bus2.in_ready, bus2.out_data};
    endfunction

    task automatic test_zero_pad();
        logic [35:0] e2;
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data = {10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1};
        #1;
        e2 = {6'b000001, 30'b0};
        n_total++;
        if (obs2() !== e2) $display("FAIL pad_idle: got %h expected %h", obs2(), e2); else n_pass++;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        e2 = {6'b100100, 10'd3, 10'd2, 10'd1};
        n_total++;
        if (obs2() !== e2) $display("FAIL pad_beat0: got %h expected %h", obs2(), e2); else n_pass++;
        @(negedge clk);
        #1;
        e2 = {6'b101000, 10'd6, 10'd5, 10'd4};
        n_total++;
        if (obs2() !== e2) $display("FAIL pad_beat1: got %h expected %h", obs2(), e2); else n_pass++;
        @(negedge clk);
        #1;
        e2 = {6'b110011, 10'd0, 10'd0, 10'd7};
        n_total++;
        if (obs2() !== e2) $display("FAIL pad_beat2: got %h expected %h", obs2(), e2); else n_pass++;
        @(negedge clk);
        #1;
        e2 = {6'b000001, 10'd3, 10'd2, 10'd1};
        n_total++;
        if (obs2() !== e2) $display("FAIL pad_done: got %h expected %h", obs2(), e2); else n_pass++;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        a0 = beat5(1, -2, 3, -4, 5);
        a1 = beat5(-6, 7, -8, 9, -10);
        for (int k = 0; k < 3; k++) begin
            b0[k] = beat5(11 + 10*k, 12 + 10*k, 13 + 10*k, 14 + 10*k, 15 + 10*k);
            b1[k] = beat5(16 + 10*k, 17 + 10*k, 18 + 10*k, 19 + 10*k, 20 + 10*k);
        end
        bus.enable = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = {a1, a0};
        bus.out_ready = 1'b1;
`ifdef SI_TO_SOE_GEN_ZERO_PAD_EN
        bus2.enable = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.in_data = '0;
        bus2.out_ready = 1'b1;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_enable();
        test_reset_mid();
`ifdef SI_TO_SOE_GEN_ZERO_PAD_EN
        test_zero_pad();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
